mem_port_arbiter: RTL and testbench

//  Shares the single-port 256x32 unified Memory between the instruction-fetch
//  (I) and load/store (D) requesters of the multicycle MIPS core. One access per

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_port_arbiter_if.sv | 31 +++
 rtl/arb_prio_starve.sv | 53 +++++
 rtl/mem_port_arbiter.sv | 91 +++++++++
 tb/tb_mem_port_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the fetch/data memory port arbiter: owner state encoding,
// default geometry and the address legality helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_D    = 2'd1,
        ARB_I    = 2'd2
    } arb_state_e;

    localparam int unsigned MEM_WORDS_DEF    = 256;
    localparam int unsigned STARVE_LIMIT_DEF = 4;
    localparam int unsigned WORD_ADDR_LSB    = 2;

    // Word aligned and inside the memory image.
    function automatic logic addr_legal(input logic [31:0] addr, input logic [31:0] limit);
        return (addr[WORD_ADDR_LSB-1:0] == '0) && (addr < limit);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch (i_*) and load/store (d_*) request/response bus between the core and the
// memory port arbiter.
interface mem_port_arbiter_if;

    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic        err;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, err
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, err
    );

endinterface

// File: rtl/arb_prio_starve.sv
// Data-first priority pick with a starvation counter that forces a fetch grant after
// STARVE_LIMIT consecutive data grants taken while fetch was waiting.
module arb_prio_starve import mem_arb_pkg::*; #(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_fetch_req,
    input  logic i_data_req,
    output logic o_fetch_gnt,
    output logic o_data_gnt
);

    localparam int unsigned    CntW   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

    logic [CntW-1:0] r_starve_cnt;
    logic [CntW-1:0] w_starve_cnt_nxt;
    logic            w_starved;

    assign w_starved = (r_starve_cnt == CntMax);

    // Grants are suppressed while reset is held so Memory sees no access.
    always_comb begin
        o_fetch_gnt = 1'b0;
        o_data_gnt  = 1'b0;
        if (rst_n) begin
            if (i_data_req && !(i_fetch_req && w_starved)) begin
                o_data_gnt = 1'b1;
            end else if (i_fetch_req) begin
                o_fetch_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        w_starve_cnt_nxt = r_starve_cnt;
        if (o_fetch_gnt || !i_fetch_req) begin
            w_starve_cnt_nxt = '0;
        end else if (o_data_gnt && !w_starved) begin
            w_starve_cnt_nxt = r_starve_cnt + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else begin
            r_starve_cnt <= w_starve_cnt_nxt;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port unified Memory between fetch and load/store: one access per
// cycle, registered read responses one cycle after the grant, error on illegal access.
module mem_port_arbiter import mem_arb_pkg::*; #(
    parameter int unsigned MEM_WORDS    = MEM_WORDS_DEF,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [31:0] AddrLimit = 32'(MEM_WORDS << WORD_ADDR_LSB);

    logic        w_i_gnt;
    logic        w_d_gnt;
    logic        w_legal;
    logic        w_d_resp;
    logic [31:0] w_rdata;
    arb_state_e  w_state_nxt;

    arb_state_e  r_state;
    logic        r_d_resp;
    logic        r_err;
    logic [31:0] r_i_rdata;
    logic [31:0] r_d_rdata;

    arb_prio_starve #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_fetch_req (bus.i_req),
        .i_data_req  (bus.d_req),
        .o_fetch_gnt (w_i_gnt),
        .o_data_gnt  (w_d_gnt)
    );

    always_comb begin
        mem_addr    = '0;
        mem_wdata   = '0;
        w_state_nxt = ARB_IDLE;
        if (w_d_gnt) begin
            mem_addr    = bus.d_addr;
            mem_wdata   = bus.d_wdata;
            w_state_nxt = ARB_D;
        end else if (w_i_gnt) begin
            mem_addr    = bus.i_addr;
            w_state_nxt = ARB_I;
        end
    end

    assign w_legal  = addr_legal(mem_addr, AddrLimit);
    assign mem_we   = w_d_gnt & bus.d_we & w_legal;
    assign w_rdata  = w_legal ? mem_rdata : '0;
    // Loads always answer; an illegal store also answers (with zero) so it retires.
    assign w_d_resp = w_d_gnt & (~bus.d_we | ~w_legal);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ARB_IDLE;
            r_d_resp  <= 1'b0;
            r_err     <= 1'b0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_d_resp <= w_d_resp;
            r_err    <= (w_i_gnt | w_d_gnt) & ~w_legal;
            if (w_i_gnt) begin
                r_i_rdata <= w_rdata;
            end
            if (w_d_resp) begin
                r_d_rdata <= w_rdata;
            end
        end
    end

    assign bus.i_gnt    = w_i_gnt;
    assign bus.d_gnt    = w_d_gnt;
    // A response still in flight is dropped as soon as reset is asserted.
    assign bus.i_rvalid = rst_n & (r_state == ARB_I);
    assign bus.d_rvalid = rst_n & (r_state == ARB_D) & r_d_resp;
    assign bus.err      = rst_n & r_err;
    assign bus.i_rdata  = r_i_rdata;
    assign bus.d_rdata  = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a zero-initialised 256x32 Memory and a
// cycle-level behavioural model checked every cycle.
module tb_mem_port_arbiter;

    localparam int unsigned MEM_WORDS    = 256;
    localparam int unsigned STARVE_LIMIT = 4;

    logic        clk;
    logic        rst_n;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .MEM_WORDS    (MEM_WORDS),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Memory: combinational read, write on posedge.
    logic [31:0] tb_mem [MEM_WORDS] = '{default: 32'h0};
    assign mem_rdata = tb_mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_addr[9:2]] <= mem_wdata;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: arbitration by waiting count, responses one cycle later.
    int unsigned m_wait = 0;
    logic        m_pi = 1'b0, m_pd = 1'b0, m_pe = 1'b0;
    logic [31:0] m_ird = '0, m_drd = '0;
    logic [31:0] m_mem [MEM_WORDS] = '{default: 32'h0};

    always @(negedge clk) begin : model
        logic        e_i, e_d, e_legal, e_we;
        logic [31:0] e_addr, e_wdata, e_rd;
        e_i = 1'b0;
        e_d = 1'b0;
        if (rst_n) begin
            if (bus.d_req && bus.i_req) begin
                if (m_wait >= STARVE_LIMIT) e_i = 1'b1;
                else                        e_d = 1'b1;
            end else if (bus.d_req) begin
                e_d = 1'b1;
            end else if (bus.i_req) begin
                e_i = 1'b1;
            end
        end
        e_addr  = e_d ? bus.d_addr : (e_i ? bus.i_addr : 32'h0);
        e_wdata = e_d ? bus.d_wdata : 32'h0;
        e_legal = (e_addr % 4 == 0) && (e_addr < 4 * MEM_WORDS);
        e_we    = e_d && bus.d_we && e_legal;
        e_rd    = e_legal ? m_mem[(e_addr / 4) % MEM_WORDS] : 32'h0;

        chk("m_i_gnt", 32'(bus.i_gnt), 32'(e_i));
        chk("m_d_gnt", 32'(bus.d_gnt), 32'(e_d));
        chk("m_mem_we", 32'(mem_we), 32'(e_we));
        chk("m_mem_addr", mem_addr, e_addr);
        chk("m_mem_wdata", mem_wdata, e_wdata);
        chk("m_i_rvalid", 32'(bus.i_rvalid), 32'(m_pi && rst_n));
        chk("m_d_rvalid", 32'(bus.d_rvalid), 32'(m_pd && rst_n));
        chk("m_err", 32'(bus.err), 32'(m_pe && rst_n));
        chk("m_i_rdata", bus.i_rdata, m_ird);
        chk("m_d_rdata", bus.d_rdata, m_drd);

        if (!rst_n) begin
            m_wait = 0;
            m_pi   = 1'b0;
            m_pd   = 1'b0;
            m_pe   = 1'b0;
            m_ird  = '0;
            m_drd  = '0;
        end else begin
            m_wait = (e_d && bus.i_req) ? m_wait + 1 : 0;
            m_pi   = e_i;
            if (e_i) m_ird = e_rd;
            m_pd   = e_d && (!bus.d_we || !e_legal);
            if (m_pd) m_drd = e_rd;
            m_pe   = (e_i || e_d) && !e_legal;
            if (e_we) m_mem[e_addr / 4] = e_wdata;
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
        bus.d_req   = req;
        bus.d_we    = we;
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
    endtask

    task automatic set_i(input logic req, input logic [31:0] addr);
        bus.i_req  = req;
        bus.i_addr = addr;
    endtask

    initial begin
        rst_n = 1'b0;
        set_i(1'b1, 32'h0);
        set_d(1'b1, 1'b1, 32'h10, 32'h1234_5678);

        // Reset with both requests high.
        for (int k = 0; k < 2; k++) begin
            cyc();
            chk("rst_i_gnt", 32'(bus.i_gnt), 32'h0);
            chk("rst_d_gnt", 32'(bus.d_gnt), 32'h0);
            chk("rst_mem_we", 32'(mem_we), 32'h0);
            chk("rst_rvalid", {30'h0, bus.i_rvalid, bus.d_rvalid}, 32'h0);
            adv();
        end

        // Store then load the same word back to back, then preload fetch words.
        rst_n = 1'b1;
        set_i(1'b0, 32'h0);
        set_d(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
        cyc();
        chk("st_d_gnt", 32'(bus.d_gnt), 32'h1);
        chk("st_mem_we", 32'(mem_we), 32'h1);
        adv();
        set_d(1'b1, 1'b0, 32'h10, 32'h0);
        cyc();
        chk("ld_mem_we", 32'(mem_we), 32'h0);
        chk("st_no_rvalid", 32'(bus.d_rvalid), 32'h0);
        adv();
        set_d(1'b1, 1'b1, 32'h0, 32'hA5A5_A5A5);
        cyc();
        chk("raw_rvalid", 32'(bus.d_rvalid), 32'h1);
        chk("raw_rdata", bus.d_rdata, 32'hDEAD_BEEF);
        adv();
        set_d(1'b1, 1'b1, 32'h4, 32'h1111_1111);
        adv();
        set_d(1'b1, 1'b1, 32'h8, 32'h2222_2222);
        adv();

        // Both requesting continuously: D,D,D,D,I repeating.
        set_i(1'b1, 32'h0);
        set_d(1'b1, 1'b0, 32'h10, 32'h0);
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk("starve_d_gnt", 32'(bus.d_gnt), (k == 4 || k == 9) ? 32'h0 : 32'h1);
            chk("starve_i_gnt", 32'(bus.i_gnt), (k == 4 || k == 9) ? 32'h1 : 32'h0);
            adv();
        end

        // Fetch-only burst.
        set_d(1'b0, 1'b0, 32'h0, 32'h0);
        set_i(1'b1, 32'h0);
        cyc();
        chk("f0_gnt", 32'(bus.i_gnt), 32'h1);
        adv();
        set_i(1'b1, 32'h4);
        cyc();
        chk("f1_gnt", 32'(bus.i_gnt), 32'h1);
        chk("f0_rvalid", 32'(bus.i_rvalid), 32'h1);
        chk("f0_rdata", bus.i_rdata, 32'hA5A5_A5A5);
        adv();
        set_i(1'b1, 32'h8);
        cyc();
        chk("f2_gnt", 32'(bus.i_gnt), 32'h1);
        chk("f1_rdata", bus.i_rdata, 32'h1111_1111);
        adv();
        set_i(1'b0, 32'h0);
        cyc();
        chk("f2_rvalid", 32'(bus.i_rvalid), 32'h1);
        chk("f2_rdata", bus.i_rdata, 32'h2222_2222);
        adv();

        // Illegal accesses, then the last legal word and a check that 0x10 is intact.
        set_d(1'b1, 1'b1, 32'h12, 32'hFFFF_FFFF);
        cyc();
        chk("mis_d_gnt", 32'(bus.d_gnt), 32'h1);
        chk("mis_mem_we", 32'(mem_we), 32'h0);
        adv();
        set_d(1'b1, 1'b0, 32'h400, 32'h0);
        cyc();
        chk("mis_err", 32'(bus.err), 32'h1);
        chk("mis_rdata", bus.d_rdata, 32'h0);
        adv();
        set_d(1'b1, 1'b0, 32'h3FC, 32'h0);
        cyc();
        chk("oor_err", 32'(bus.err), 32'h1);
        chk("oor_rvalid", 32'(bus.d_rvalid), 32'h1);
        chk("oor_rdata", bus.d_rdata, 32'h0);
        adv();
        set_d(1'b1, 1'b0, 32'h10, 32'h0);
        cyc();
        chk("top_err", 32'(bus.err), 32'h0);
        adv();
        set_d(1'b0, 1'b0, 32'h0, 32'h0);
        cyc();
        chk("intact_rdata", bus.d_rdata, 32'hDEAD_BEEF);
        adv();

        // Build up starvation, reset right after a load grant, then restart fresh.
        set_i(1'b1, 32'h0);
        set_d(1'b1, 1'b0, 32'h4, 32'h0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("pre_d_gnt", 32'(bus.d_gnt), 32'h1);
            adv();
        end
        rst_n = 1'b0;
        set_i(1'b0, 32'h0);
        set_d(1'b0, 1'b0, 32'h0, 32'h0);
        cyc();
        chk("midrst_rvalid", 32'(bus.d_rvalid), 32'h0);
        adv();
        rst_n = 1'b1;
        set_i(1'b1, 32'h0);
        set_d(1'b1, 1'b0, 32'h4, 32'h0);
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("post_d_gnt", 32'(bus.d_gnt), (k == 4) ? 32'h0 : 32'h1);
            if (k == 0) chk("post_rvalid", 32'(bus.d_rvalid), 32'h0);
            adv();
        end
        set_i(1'b0, 32'h0);
        set_d(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) adv();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
